phy_rx_decode_64b66b: RTL and testbench
=======================================

# phy_rx_decode_64b66b

Receive-side 64B/66B descrambler and block decoder placed directly downstream of the RX block-lock (bit-sync) stage. Consumes the gearbox's 2-bit sync header and 64-bit payload, self-synchronously descrambles the payload, and decodes start, data, terminate and idle blocks. Repacks frame bytes into contiguous 8-byte words on a valid/last/keep stream for the MAC. Decoding is enabled only while block lock is held.

## Interface
- P_SCRAMBLE_BYPASS, 0: 1 = payload passes through unscrambled; the descrambler history still updates.
- i_clk  in  1  RX user clock (GT RX usrclk2)
- i_rst  in  1  reset; synchronous, active-high
- i_header  in  2  sync header of the current block (01 data, 10 control)
- i_data  in  64  scrambled payload; i_data[0] first bit on the wire, byte n = i_data[8n+7:8n]
- i_data_valid  in  1  block valid strobe from the gearbox; may drop for single cycles
- i_sync  in  1  block lock from the bit-sync stage
- o_rx_axis_data  out  64  frame bytes, byte 0 in [7:0]
- o_rx_axis_keep  out  8  byte enables, contiguous from bit 0
- o_rx_axis_last  out  1  last word of the frame
- o_rx_axis_valid  out  1  word strobe; no backpressure exists
- o_rx_err  out  1  one-cycle pulse on a decode error

## Operation
- Descrambler, polynomial x^58+x^39+1:
  - Each payload bit d[i] = s[i] ^ s[i-39] ^ s[i-58], where s is the received (scrambled) serial bit stream.
  - 58-bit history = the last 58 scrambled bits. It is updated on every i_data_valid block regardless of i_sync. Reset value is 0.
  - The header is never scrambled.
- Block types (byte 0 of a descrambled control block):
  - 0x1E idle
  - 0x78 start: bytes 1-7 are payload
  - Terminate: 0x87/0x99/0xAA/0xB4/0xCC/0xD2/0xE1/0xFF carry n = 0..7 payload bytes in bytes 1..n.
- Decoder state machine IDLE/FRAME; reset to IDLE. It has a 7-byte carry register (C).
- IDLE:
  - start: C = bytes 1-7, go to FRAME, no output.
  - idle: no action.
  - Data block: discarded, o_rx_err pulse.
  - Header 00/11 or unknown type: o_rx_err pulse only.
- FRAME, data block: output {byte0, C}, keep 0xFF; C = bytes 1-7.
- FRAME, terminate with n bytes:
  - n=0: output C, keep 0x7F, last.
  - n=1: output {byte1, C}, keep 0xFF, last.
  - n>=2: output {byte1, C}, keep 0xFF. Then a pending tail word of bytes 2..n, keep = (1<<(n-1))-1, last.
  - Go to IDLE.
- FRAME, error (start, idle, header 00/11, unknown type): output C, keep 0x7F, last, o_rx_err pulse, go to IDLE.
  - A start block in this position is not itself loaded; the next frame begins at the next start.
- i_sync low while in FRAME: abort word (C, keep 0x7F, last, o_rx_err), go to IDLE. While i_sync is low, all blocks are ignored.

## Timing
- Reset values:
  - o_rx_axis_valid, o_rx_axis_last and o_rx_err are 0.
  - o_rx_axis_data, o_rx_axis_keep and C are 0.
  - The descrambler history is 0.
- Reset mid-frame drops the frame silently; no last word is emitted.
- Pipeline: descramble register, then decode/repack register.
  - The output word for a block appears 2 i_clk cycles after that block's i_data_valid cycle.
  - The tail word appears on the cycle after the word it follows.
- A tail word takes priority in its cycle.
  - If the next block is a start in that cycle, C loads in the same cycle; start never produces output, so no word is lost.
- Cycles with i_data_valid=0 advance nothing; the tail word is still emitted.
- o_rx_axis_valid never stays high for more than 2 consecutive cycles per input block.

## Structure
- Package phy_64b66b_pkg holds:
  - header constants (2'b01 data, 2'b10 control)
  - block-type constants
  - a function mapping terminate type to byte count n
  - a decoder state typedef
- Sub-module phy_rx_descrambler: 64-bit parallel descrambler with the 58-bit history, valid in/out, and P_SCRAMBLE_BYPASS.

## Test plan
- Bypass=1, i_sync=1: start (bytes 1-7 = 01..07), data block 08..0F, terminate 0xCC (4 bytes 10..13) -> words:
  - {08,07..01} keep FF
  - {10,0F..09} keep FF
  - {13..11} keep 07, last
- Bypass=0: the stream is scrambled by a bench model of x^58+x^39+1 from a zero initial state -> same three words. Then 1000 random frames compare against the model.
- Terminate sweep n=0..7 after a single data block -> tail keep per rule (n=0: 7F last; n=1: FF last; n=7: 3F tail last).
- Data block while IDLE, then header 2'b11 mid-frame -> o_rx_err pulses. The mid-frame one yields keep 7F with last.
- i_sync drops mid-frame -> abort word with last and err, then no output until the next start after i_sync is high again.
- Pulse i_data_valid low every 32nd cycle during frames, and issue a start immediately after a terminate with n=5 -> no lost or reordered bytes, and the tail word is emitted.

Source files
------------

// File: rtl/phy_rx_decode_64b66b_pkg.sv
`default_nettype none
// ============================================================================
// phy_64b66b_pkg : shared 64B/66B header, block-type and decoder definitions
// Rev 1.0
// ============================================================================
package phy_64b66b_pkg;

  localparam logic [1:0] c_hdr_data = 2'b01;
  localparam logic [1:0] c_hdr_ctrl = 2'b10;

  localparam int c_descr_hist_w = 58;

  localparam logic [7:0] c_bt_idle  = 8'h1E;
  localparam logic [7:0] c_bt_start = 8'h78;
  localparam logic [7:0] c_bt_term0 = 8'h87;
  localparam logic [7:0] c_bt_term1 = 8'h99;
  localparam logic [7:0] c_bt_term2 = 8'hAA;
  localparam logic [7:0] c_bt_term3 = 8'hB4;
  localparam logic [7:0] c_bt_term4 = 8'hCC;
  localparam logic [7:0] c_bt_term5 = 8'hD2;
  localparam logic [7:0] c_bt_term6 = 8'hE1;
  localparam logic [7:0] c_bt_term7 = 8'hFF;

  typedef enum logic [0:0] {
    DEC_IDLE  = 1'b0,
    DEC_FRAME = 1'b1
  } dec_state_t;

  typedef struct packed {
    logic       is_term;
    logic [2:0] nbytes;
  } term_info_t;

  function automatic term_info_t term_decode(input logic [7:0] btype);
    term_info_t t;
    t = '{is_term: 1'b1, nbytes: 3'd0};
    case (btype)
      c_bt_term0: t.nbytes = 3'd0;
      c_bt_term1: t.nbytes = 3'd1;
      c_bt_term2: t.nbytes = 3'd2;
      c_bt_term3: t.nbytes = 3'd3;
      c_bt_term4: t.nbytes = 3'd4;
      c_bt_term5: t.nbytes = 3'd5;
      c_bt_term6: t.nbytes = 3'd6;
      c_bt_term7: t.nbytes = 3'd7;
      default:    t.is_term = 1'b0;
    endcase
    return t;
  endfunction

  // Keep mask for the tail word holding terminate bytes 2..n.
  function automatic logic [7:0] tail_keep(input logic [2:0] n);
    logic [7:0] k;
    k = '0;
    for (int i = 0; i < 7; i++) begin
      if ((i + 1) < int'(n)) k[i] = 1'b1;
    end
    return k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/phy_rx_decode_64b66b_if.sv
`default_nettype none
// ============================================================================
// phy_rx_decode_64b66b_if : gearbox block input and MAC byte-stream output
// Rev 1.0
// ============================================================================
interface phy_rx_decode_64b66b_if;
  logic [1:0]  i_header;
  logic [63:0] i_data;
  logic        i_data_valid;
  logic        i_sync;
  logic [63:0] o_rx_axis_data;
  logic [7:0]  o_rx_axis_keep;
  logic        o_rx_axis_last;
  logic        o_rx_axis_valid;
  logic        o_rx_err;

  modport master (
    output i_header, i_data, i_data_valid, i_sync,
    input  o_rx_axis_data, o_rx_axis_keep, o_rx_axis_last, o_rx_axis_valid, o_rx_err
  );

  modport slave (
    input  i_header, i_data, i_data_valid, i_sync,
    output o_rx_axis_data, o_rx_axis_keep, o_rx_axis_last, o_rx_axis_valid, o_rx_err
  );
endinterface
`default_nettype wire

// File: rtl/phy_rx_descrambler.sv
`default_nettype none
// ============================================================================
// phy_rx_descrambler : 64-bit parallel self-synchronous x^58+x^39+1 descrambler
// Rev 1.0
// ============================================================================
module phy_rx_descrambler
  import phy_64b66b_pkg::*;
#(
  parameter bit P_SCRAMBLE_BYPASS = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_header,
  input  logic [63:0] i_data,
  input  logic        i_valid,
  input  logic        i_sync,
  output logic [1:0]  o_header,
  output logic [63:0] o_data,
  output logic        o_valid,
  output logic        o_sync
);

  logic [c_descr_hist_w-1:0]    hist_q;
  logic [1:0]                   hdr_q;
  logic [63:0]                  data_q;
  logic                         valid_q;
  logic                         sync_q;
  logic [c_descr_hist_w+63:0]   w_ext;
  logic [63:0]                  w_descr;
  logic [63:0]                  w_payload;

  // w_ext[58+i] is received bit i; lower indices reach back into history.
  assign w_ext = {i_data, hist_q};

  always_comb begin
    w_descr = '0;
    for (int i = 0; i < 64; i++) begin
      w_descr[i] = w_ext[c_descr_hist_w + i] ^ w_ext[19 + i] ^ w_ext[i];
    end
  end

  assign w_payload = P_SCRAMBLE_BYPASS ? i_data : w_descr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hist_q  <= '0;
      hdr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      valid_q <= i_valid;
      sync_q  <= i_sync;
      if (i_valid) begin
        hist_q <= i_data[63:64-c_descr_hist_w];
        hdr_q  <= i_header;
        data_q <= w_payload;
      end
    end
  end

  assign o_header = hdr_q;
  assign o_data   = data_q;
  assign o_valid  = valid_q;
  assign o_sync   = sync_q;

endmodule
`default_nettype wire

// File: rtl/phy_rx_decode_64b66b.sv
`default_nettype none
// ============================================================================
// phy_rx_decode_64b66b : 64B/66B descramble, block decode and 8-byte repack
// Rev 1.0
// ============================================================================
module phy_rx_decode_64b66b
  import phy_64b66b_pkg::*;
#(
  parameter bit P_SCRAMBLE_BYPASS = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  phy_rx_decode_64b66b_if.slave   bus_io
);

  logic [1:0]  w_hdr;
  logic [63:0] w_blk;
  logic        w_blk_valid;
  logic        w_blk_sync;

  phy_rx_descrambler #(
    .P_SCRAMBLE_BYPASS (P_SCRAMBLE_BYPASS)
  ) u_descr (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_header (bus_io.i_header),
    .i_data   (bus_io.i_data),
    .i_valid  (bus_io.i_data_valid),
    .i_sync   (bus_io.i_sync),
    .o_header (w_hdr),
    .o_data   (w_blk),
    .o_valid  (w_blk_valid),
    .o_sync   (w_blk_sync)
  );

  dec_state_t  state_q;
  logic [55:0] carry_q;
  logic [63:0] data_q;
  logic [7:0]  keep_q;
  logic        last_q;
  logic        valid_q;
  logic        err_q;
  logic        tail_pend_q;
  logic [47:0] tail_data_q;
  logic [7:0]  tail_keep_q;

  logic [7:0]  w_btype;
  term_info_t  w_term;
  logic        w_is_ctrl;
  logic        w_is_start;
  logic        w_is_idle;
  logic [7:0]  w_tail_keep;
  logic [47:0] w_tail_data;

  assign w_btype     = w_blk[7:0];
  assign w_term      = term_decode(w_btype);
  assign w_is_ctrl   = (w_hdr == c_hdr_ctrl);
  assign w_is_start  = w_is_ctrl && (w_btype == c_bt_start);
  assign w_is_idle   = w_is_ctrl && (w_btype == c_bt_idle);
  assign w_tail_keep = tail_keep(w_term.nbytes);

  // Bytes beyond the terminate count are zeroed so the tail word is clean.
  always_comb begin
    w_tail_data = '0;
    for (int j = 0; j < 6; j++) begin
      w_tail_data[8*j +: 8] = w_tail_keep[j] ? w_blk[16 + 8*j +: 8] : 8'h00;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= DEC_IDLE;
      carry_q     <= '0;
      data_q      <= '0;
      keep_q      <= '0;
      last_q      <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      tail_pend_q <= 1'b0;
      tail_data_q <= '0;
      tail_keep_q <= '0;
    end else begin
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      tail_pend_q <= 1'b0;

      // A pending tail only exists in IDLE, where blocks never emit a word.
      if (tail_pend_q) begin
        valid_q <= 1'b1;
        data_q  <= {16'h0000, tail_data_q};
        keep_q  <= tail_keep_q;
        last_q  <= 1'b1;
      end

      if ((state_q == DEC_FRAME) && !w_blk_sync) begin
        valid_q <= 1'b1;
        data_q  <= {8'h00, carry_q};
        keep_q  <= 8'h7F;
        last_q  <= 1'b1;
        err_q   <= 1'b1;
        state_q <= DEC_IDLE;
      end else if (w_blk_valid && w_blk_sync) begin
        case (state_q)
          DEC_IDLE: begin
            if (w_is_start) begin
              carry_q <= w_blk[63:8];
              state_q <= DEC_FRAME;
            end else if (!w_is_idle) begin
              err_q <= 1'b1;
            end
          end
          DEC_FRAME: begin
            if (w_hdr == c_hdr_data) begin
              valid_q <= 1'b1;
              data_q  <= {w_blk[7:0], carry_q};
              keep_q  <= 8'hFF;
              carry_q <= w_blk[63:8];
            end else if (w_is_ctrl && w_term.is_term) begin
              valid_q <= 1'b1;
              state_q <= DEC_IDLE;
              if (w_term.nbytes == 3'd0) begin
                data_q <= {8'h00, carry_q};
                keep_q <= 8'h7F;
                last_q <= 1'b1;
              end else begin
                data_q      <= {w_blk[15:8], carry_q};
                keep_q      <= 8'hFF;
                last_q      <= (w_term.nbytes == 3'd1);
                tail_pend_q <= (w_term.nbytes >= 3'd2);
                tail_data_q <= w_tail_data;
                tail_keep_q <= w_tail_keep;
              end
            end else begin
              valid_q <= 1'b1;
              data_q  <= {8'h00, carry_q};
              keep_q  <= 8'h7F;
              last_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= DEC_IDLE;
            end
          end
          default: state_q <= DEC_IDLE;
        endcase
      end
    end
  end

  assign bus_io.o_rx_axis_data  = data_q;
  assign bus_io.o_rx_axis_keep  = keep_q;
  assign bus_io.o_rx_axis_last  = last_q;
  assign bus_io.o_rx_axis_valid = valid_q;
  assign bus_io.o_rx_err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_phy_rx_decode_64b66b.sv
`default_nettype none
// ============================================================================
// tb_phy_rx_decode_64b66b : bypass and scrambled decoders against a frame model
// Rev 1.0
// ============================================================================
module tb_phy_rx_decode_64b66b;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  phy_rx_decode_64b66b_if bus_a ();
  phy_rx_decode_64b66b_if bus_b ();

  phy_rx_decode_64b66b #(.P_SCRAMBLE_BYPASS(1'b1)) u_dut_a (
    .i_clk (clk), .i_rst (rst), .bus_io (bus_a)
  );
  phy_rx_decode_64b66b #(.P_SCRAMBLE_BYPASS(1'b0)) u_dut_b (
    .i_clk (clk), .i_rst (rst), .bus_io (bus_b)
  );

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   err_idle [2];
  int   exp_err_idle = 0;
  logic gap_mode = 1'b0;
  logic [57:0] sc_state = '0;
  exp_t qa [$];
  exp_t qb [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int id, input logic v, input logic [63:0] d,
                     input logic [7:0] k, input logic l, input logic e);
    exp_t x;
    logic [63:0] m;
    int sz;
    if (v) begin
      sz = (id == 0) ? qa.size() : qb.size();
      total++;
      assert (sz != 0) else begin
        bad++;
        $error("FAIL unexpected_word dut=%0d obs=%0h exp=none", id, d);
      end
      if (sz != 0) begin
        x = (id == 0) ? qa.pop_front() : qb.pop_front();
        for (int j = 0; j < 8; j++) m[8*j +: 8] = {8{x.keep[j]}};
        chk($sformatf("data dut=%0d", id), d & m, x.data & m);
        chk($sformatf("keep dut=%0d", id), {56'h0, k}, {56'h0, x.keep});
        chk($sformatf("last dut=%0d", id), {63'h0, l}, {63'h0, x.last});
        chk($sformatf("err dut=%0d", id), {63'h0, e}, {63'h0, x.err});
      end
    end else if (e) begin
      err_idle[id]++;
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus_a.o_rx_axis_valid, bus_a.o_rx_axis_data, bus_a.o_rx_axis_keep,
        bus_a.o_rx_axis_last, bus_a.o_rx_err);
    mon(1, bus_b.o_rx_axis_valid, bus_b.o_rx_axis_data, bus_b.o_rx_axis_keep,
        bus_b.o_rx_axis_last, bus_b.o_rx_err);
  end

  task automatic push_exp(input exp_t e);
    qa.push_back(e);
    qb.push_back(e);
  endtask

  // Frame bytes are chunked into 8-byte words; the final chunk carries last/err.
  task automatic push_words(input logic [7:0] b[$], input logic err);
    exp_t e;
    for (int i = 0; i < b.size(); i += 8) begin
      e = '0;
      for (int j = 0; j < 8; j++) begin
        if (i + j < b.size()) begin
          e.data[8*j +: 8] = b[i + j];
          e.keep[j] = 1'b1;
        end
      end
      e.last = (i + 8 >= b.size());
      e.err  = e.last && err;
      push_exp(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic [1:0] h, input logic [63:0] p);
    logic [63:0] s;
    logic sb;
    if (gap_mode && (cyc % 32 == 31)) tick();
    for (int i = 0; i < 64; i++) begin
      sb = p[i] ^ sc_state[38] ^ sc_state[57];
      s[i] = sb;
      sc_state = {sc_state[56:0], sb};
    end
    bus_a.i_header = h; bus_a.i_data = p; bus_a.i_data_valid = 1'b1;
    bus_b.i_header = h; bus_b.i_data = s; bus_b.i_data_valid = 1'b1;
    tick();
    bus_a.i_data_valid = 1'b0;
    bus_b.i_data_valid = 1'b0;
  endtask

  task automatic set_sync(input logic v);
    bus_a.i_sync = v;
    bus_b.i_sync = v;
  endtask

  task automatic idle_blk();
    drive(2'b10, 64'h1E);
  endtask

  function automatic logic [7:0] term_type(input int n);
    case (n)
      0: return 8'h87;  1: return 8'h99;  2: return 8'hAA;  3: return 8'hB4;
      4: return 8'hCC;  5: return 8'hD2;  6: return 8'hE1;  default: return 8'hFF;
    endcase
  endfunction

  task automatic rand_bytes(input int cnt, output logic [7:0] b[$]);
    b = {};
    for (int i = 0; i < cnt; i++) b.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic drive_start_data(input logic [7:0] b[$], input int k);
    logic [63:0] p;
    p = 64'h78;
    for (int j = 0; j < 7; j++) p[8*(j+1) +: 8] = b[j];
    drive(2'b10, p);
    for (int i = 0; i < k; i++) begin
      for (int j = 0; j < 8; j++) p[8*j +: 8] = b[7 + 8*i + j];
      drive(2'b01, p);
    end
  endtask

  task automatic send_frame(input int k, input int n);
    logic [7:0] b[$];
    logic [63:0] p;
    rand_bytes(7 + 8*k + n, b);
    push_words(b, 1'b0);
    drive_start_data(b, k);
    p = '0;
    p[7:0] = term_type(n);
    for (int j = 0; j < n; j++) p[8*(j+1) +: 8] = b[7 + 8*k + j];
    drive(2'b10, p);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_a.i_data_valid = 1'b0;
    bus_b.i_data_valid = 1'b0;
    sc_state = '0;
    repeat (3) tick();
    chk("rst_valid_a", {63'h0, bus_a.o_rx_axis_valid}, 64'h0);
    chk("rst_last_a",  {63'h0, bus_a.o_rx_axis_last},  64'h0);
    chk("rst_err_a",   {63'h0, bus_a.o_rx_err},        64'h0);
    chk("rst_data_a",  bus_a.o_rx_axis_data,           64'h0);
    chk("rst_keep_a",  {56'h0, bus_a.o_rx_axis_keep},  64'h0);
    chk("rst_valid_b", {63'h0, bus_b.o_rx_axis_valid}, 64'h0);
    chk("rst_last_b",  {63'h0, bus_b.o_rx_axis_last},  64'h0);
    chk("rst_err_b",   {63'h0, bus_b.o_rx_err},        64'h0);
    chk("rst_data_b",  bus_b.o_rx_axis_data,           64'h0);
    chk("rst_keep_b",  {56'h0, bus_b.o_rx_axis_keep},  64'h0);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] b[$];
    exp_t e;
    err_idle[0] = 0;
    err_idle[1] = 0;
    bus_a.i_header = 2'b00; bus_a.i_data = '0; bus_a.i_data_valid = 1'b0; bus_a.i_sync = 1'b1;
    bus_b.i_header = 2'b00; bus_b.i_data = '0; bus_b.i_data_valid = 1'b0; bus_b.i_sync = 1'b1;
    #1;
    do_reset();

    // Directed frame with fixed expected words.
    push_exp('{data: 64'h0807060504030201, keep: 8'hFF, last: 1'b0, err: 1'b0});
    push_exp('{data: 64'h100F0E0D0C0B0A09, keep: 8'hFF, last: 1'b0, err: 1'b0});
    push_exp('{data: 64'h0000000000131211, keep: 8'h07, last: 1'b1, err: 1'b0});
    drive(2'b10, 64'h0706050403020178);
    drive(2'b01, 64'h0F0E0D0C0B0A0908);
    drive(2'b10, 64'h00000013121110CC);
    idle_blk();
    idle_blk();

    for (int n = 0; n < 8; n++) begin
      send_frame(1, n);
      idle_blk();
    end

    // Data block in IDLE, then a header-11 block mid-frame.
    drive(2'b01, 64'hDEADBEEF01234567);
    exp_err_idle++;
    rand_bytes(15, b);
    push_words(b, 1'b1);
    drive_start_data(b, 1);
    drive(2'b11, 64'h0123456789ABCDEF);
    idle_blk();

    // Block lock lost mid-frame; everything until relock is ignored.
    rand_bytes(15, b);
    push_words(b, 1'b1);
    drive_start_data(b, 1);
    set_sync(1'b0);
    drive(2'b01, 64'h1111111111111111);
    drive(2'b10, 64'h2222222222222278);
    drive(2'b01, 64'h3333333333333333);
    drive(2'b10, 64'h00000000444444CC);
    repeat (2) tick();
    set_sync(1'b1);
    repeat (2) tick();
    idle_blk();
    send_frame(1, 3);
    idle_blk();

    // Mid-frame reset drops the frame with no last word.
    rand_bytes(15, b);
    e = '0;
    for (int j = 0; j < 8; j++) e.data[8*j +: 8] = b[j];
    e.keep = 8'hFF;
    push_exp(e);
    drive_start_data(b, 1);
    repeat (4) tick();
    do_reset();

    // Valid gaps plus back-to-back frames behind an n=5 terminate.
    gap_mode = 1'b1;
    send_frame(2, 5);
    send_frame(1, 5);
    send_frame(0, 2);
    idle_blk();

    for (int f = 0; f < 1000; f++) begin
      send_frame($urandom_range(0, 4), $urandom_range(0, 7));
      repeat ($urandom_range(0, 2)) idle_blk();
    end

    repeat (8) tick();
    chk("pending_words_a", 64'(qa.size()), 64'h0);
    chk("pending_words_b", 64'(qb.size()), 64'h0);
    chk("idle_err_a", 64'(err_idle[0]), 64'(exp_err_idle));
    chk("idle_err_b", 64'(err_idle[1]), 64'(exp_err_idle));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
